// File: rtl/wb_pkg.sv
// Shared types and sizing constants for the register-file write arbiter.
//   DATA_W_DEF / ADDR_W_DEF : default data and register-number widths
//   wb_entry_t              : one pending write {num, data} at default widths
//   STARVE_W                : width of the starvation counter (holds up to 15)
package wb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int STARVE_W   = 4;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] num;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_write_arbiter_fifo.sv
// Synchronous FIFO for long-unit write results.
//   clk, clr_n : clock, asynchronous active-low reset
//   push       : write push_data (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   head       : oldest entry, valid while !empty
//   full/empty : occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate count.
module wb_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wb_pkg::wb_entry_t
) (
    input  logic   clk,
    input  logic   clr_n,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    logic        push_ok, pop_ok;
    entry_t      mem_q [DEPTH];

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q + (PW+1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (PW+1)'(pop_ok);
        head     = mem_q[rd_ptr_q[PW-1:0]];
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port owner. Merges single-cycle WB-stage writes with
// buffered long-latency results and tracks which registers have a result
// still in flight.
//   pipe_*     : WB-stage write, always taken, beats the FIFO head
//   lu_*       : long-unit result, handshaked into the FIFO (lu_ready = !full)
//   issue_*    : marks the destination of a long-latency op busy
//   chk_num_*  : scoreboard queries, busy_* read registered bits
//   pipe_hold  : asks WB to stay idle next cycle so a starved FIFO entry drains
//   err        : sticky protocol error
//   w_en/w_number/data_in : registered register-file write port
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              pipe_w_en,
    input  logic [ADDR_W-1:0] pipe_w_num,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_w_num,
    input  logic [DATA_W-1:0] lu_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_num,
    input  logic [ADDR_W-1:0] chk_num_a,
    input  logic [ADDR_W-1:0] chk_num_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic              pipe_hold,
    output logic              err,
    output logic              w_en,
    output logic [ADDR_W-1:0] w_number,
    output logic [DATA_W-1:0] data_in
);

    localparam int NREG = 2**ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] num;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic                w_en_q, w_en_d;
    logic [ADDR_W-1:0]   w_number_q, w_number_d;
    logic [DATA_W-1:0]   data_in_q, data_in_d;
    logic [NREG-1:0]     busy_q, busy_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                pipe_hold_q, pipe_hold_d;
    logic                err_q, err_d;

    logic   fifo_full, fifo_empty;
    logic   push, pop, pipe_wr;
    entry_t lu_entry, head;

    assign lu_entry = '{num: lu_w_num, data: lu_data};

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .clr_n     (clr_n),
        .push      (push),
        .push_data (lu_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        lu_ready = !fifo_full;
        // Results for r0 complete the handshake but are never stored.
        push     = lu_valid && !fifo_full && (lu_w_num != '0);
        // Any pipe request owns the slot, even a discarded r0 write.
        pop      = !pipe_w_en && !fifo_empty;
        pipe_wr  = pipe_w_en && (pipe_w_num != '0);

        w_en_d     = pipe_wr || pop;
        w_number_d = w_number_q;
        data_in_d  = data_in_q;
        if (pipe_wr) begin
            w_number_d = pipe_w_num;
            data_in_d  = pipe_data;
        end else if (pop) begin
            w_number_d = head.num;
            data_in_d  = head.data;
        end

        // Clear first so a same-cycle issue to the same register wins.
        busy_d = busy_q;
        if (pop) begin
            busy_d[head.num] = 1'b0;
        end
        if (issue_en && (issue_num != '0)) begin
            busy_d[issue_num] = 1'b1;
        end
        busy_d[0] = 1'b0;

        err_d = err_q
              | (issue_en && (issue_num != '0) && busy_q[issue_num])
              | (push && !busy_q[lu_w_num])
              | (pipe_w_en && pipe_hold_q);

        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (starve_q < STARVE_W'(STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end else begin
            starve_d = starve_q;
        end
        pipe_hold_d = (starve_d >= STARVE_W'(STARVE_MAX));
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            w_en_q      <= 1'b0;
            w_number_q  <= '0;
            data_in_q   <= '0;
            busy_q      <= '0;
            starve_q    <= '0;
            pipe_hold_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            w_en_q      <= w_en_d;
            w_number_q  <= w_number_d;
            data_in_q   <= data_in_d;
            busy_q      <= busy_d;
            starve_q    <= starve_d;
            pipe_hold_q <= pipe_hold_d;
            err_q       <= err_d;
        end
    end

    assign busy_a    = busy_q[chk_num_a];
    assign busy_b    = busy_q[chk_num_b];
    assign pipe_hold = pipe_hold_q;
    assign err       = err_q;
    assign w_en      = w_en_q;
    assign w_number  = w_number_q;
    assign data_in   = data_in_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        pipe_w_en = 1'b0;
    logic [4:0]  pipe_w_num = '0;
    logic [31:0] pipe_data = '0;
    logic        lu_valid = 1'b0;
    logic        lu_ready;
    logic [4:0]  lu_w_num = '0;
    logic [31:0] lu_data = '0;
    logic        issue_en = 1'b0;
    logic [4:0]  issue_num = '0;
    logic [4:0]  chk_num_a = '0;
    logic [4:0]  chk_num_b = '0;
    logic        busy_a, busy_b, pipe_hold, err, w_en;
    logic [4:0]  w_number;
    logic [31:0] data_in;

    wb_write_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH), .STARVE_MAX(4)) dut (
        .clk(clk), .clr_n(clr_n),
        .pipe_w_en(pipe_w_en), .pipe_w_num(pipe_w_num), .pipe_data(pipe_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_w_num(lu_w_num), .lu_data(lu_data),
        .issue_en(issue_en), .issue_num(issue_num),
        .chk_num_a(chk_num_a), .chk_num_b(chk_num_b),
        .busy_a(busy_a), .busy_b(busy_b), .pipe_hold(pipe_hold), .err(err),
        .w_en(w_en), .w_number(w_number), .data_in(data_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic pe; logic [4:0] pn; logic [31:0] pd;
        logic lv; logic [4:0] ln; logic [31:0] ld;
        logic ie; logic [4:0] in;
        logic [4:0] ca; logic [4:0] cb;
        logic xa; logic xb; logic xerr; logic xhold;
    } vec_t;

    typedef struct { logic [4:0] num; logic [31:0] data; } ent_t;
    typedef struct { logic en; logic [4:0] num; logic [31:0] data; } wr_t;

    int n_checks = 0;
    int n_errors = 0;

    vec_t        tab[$];
    ent_t        m_fifo[$];
    wr_t         exp_q[$];
    logic [4:0]  m_last_num = '0;
    logic [31:0] m_last_data = '0;

    function automatic vec_t mk(
        input logic pe, input logic [4:0] pn, input logic [31:0] pd,
        input logic lv, input logic [4:0] ln, input logic [31:0] ld,
        input logic ie, input logic [4:0] in,
        input logic [4:0] ca, input logic [4:0] cb,
        input logic xa, input logic xb, input logic xerr, input logic xhold);
        vec_t v;
        v.pe = pe; v.pn = pn; v.pd = pd;
        v.lv = lv; v.ln = ln; v.ld = ld;
        v.ie = ie; v.in = in; v.ca = ca; v.cb = cb;
        v.xa = xa; v.xb = xb; v.xerr = xerr; v.xhold = xhold;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        exp_q.delete();
        m_last_num  = '0;
        m_last_data = '0;
    endtask

    task automatic idle_inputs();
        pipe_w_en = 1'b0; pipe_w_num = '0; pipe_data = '0;
        lu_valid = 1'b0; lu_w_num = '0; lu_data = '0;
        issue_en = 1'b0; issue_num = '0;
    endtask

    // Drive one cycle of stimulus, predict the write it must produce, then
    // compare everything visible just after the following clock edge.
    task automatic apply_vec(input vec_t v, input string tag);
        wr_t  e, got;
        ent_t ent;
        bit   m_ready;
        pipe_w_en = v.pe; pipe_w_num = v.pn; pipe_data = v.pd;
        lu_valid = v.lv; lu_w_num = v.ln; lu_data = v.ld;
        issue_en = v.ie; issue_num = v.in;
        chk_num_a = v.ca; chk_num_b = v.cb;

        m_ready = (m_fifo.size() < DEPTH);
        check({tag, " lu_ready"}, 32'(lu_ready), 32'(m_ready));

        e.en = 1'b0; e.num = m_last_num; e.data = m_last_data;
        if (v.pe) begin
            if (v.pn != 0) begin
                e.en = 1'b1; e.num = v.pn; e.data = v.pd;
            end
        end else if (m_fifo.size() > 0) begin
            ent = m_fifo.pop_front();
            e.en = 1'b1; e.num = ent.num; e.data = ent.data;
        end
        if (v.lv && m_ready && (v.ln != 0)) begin
            ent.num = v.ln; ent.data = v.ld;
            m_fifo.push_back(ent);
        end
        if (e.en) begin
            m_last_num = e.num; m_last_data = e.data;
        end
        exp_q.push_back(e);

        @(posedge clk); #1;

        got = exp_q.pop_front();
        check({tag, " w_en"}, 32'(w_en), 32'(got.en));
        check({tag, " w_number"}, 32'(w_number), 32'(got.num));
        check({tag, " data_in"}, data_in, got.data);
        check({tag, " busy_a"}, 32'(busy_a), 32'(v.xa));
        check({tag, " busy_b"}, 32'(busy_b), 32'(v.xb));
        check({tag, " err"}, 32'(err), 32'(v.xerr));
        check({tag, " pipe_hold"}, 32'(pipe_hold), 32'(v.xhold));
    endtask

    task automatic run_tab(input string pfx);
        foreach (tab[i]) apply_vec(tab[i], $sformatf("%s%0d", pfx, i));
        tab.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        @(posedge clk); #1;
        check("rst w_en", 32'(w_en), 0);
        check("rst w_number", 32'(w_number), 0);
        check("rst data_in", data_in, 0);
        check("rst lu_ready", 32'(lu_ready), 1);
        check("rst busy_a", 32'(busy_a), 0);
        check("rst pipe_hold", 32'(pipe_hold), 0);
        check("rst err", 32'(err), 0);
        clr_n = 1'b1;

        //           pe pn  pd            lv ln  ld         ie in  ca cb  xa xb er ho
        tab.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,         0, 0,  5, 7,  0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0,            0, 0, 0,         0, 0,  5, 7,  0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0,            0, 0, 0,         1, 7,  7, 3,  1, 0, 0, 0));
        tab.push_back(mk(1, 3, 1,            1, 7, 2,         0, 0,  7, 3,  1, 0, 0, 0));
        tab.push_back(mk(0, 0, 0,            0, 0, 0,         0, 0,  7, 3,  0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0,            0, 0, 0,         1, 8,  8, 10, 1, 0, 0, 0));
        tab.push_back(mk(0, 0, 0,            0, 0, 0,         1, 9,  8, 10, 1, 0, 0, 0));
        tab.push_back(mk(0, 0, 0,            0, 0, 0,         1, 10, 8, 10, 1, 1, 0, 0));
        tab.push_back(mk(1, 1, 11,           1, 8, 80,        0, 0,  8, 10, 1, 1, 0, 0));
        tab.push_back(mk(1, 2, 12,           1, 9, 90,        0, 0,  8, 10, 1, 1, 0, 0));
        tab.push_back(mk(1, 3, 13,           1, 10, 100,      0, 0,  8, 10, 1, 1, 0, 0));
        tab.push_back(mk(1, 4, 14,           1, 10, 100,      0, 0,  8, 10, 1, 1, 0, 0));
        tab.push_back(mk(0, 0, 0,            1, 10, 100,      0, 0,  8, 10, 0, 1, 0, 0));
        tab.push_back(mk(0, 0, 0,            1, 10, 100,      0, 0,  9, 10, 0, 1, 0, 0));
        tab.push_back(mk(0, 0, 0,            0, 0, 0,         0, 0,  9, 10, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0,            0, 0, 0,         1, 11, 11, 0, 1, 0, 0, 0));
        tab.push_back(mk(1, 1, 21,           1, 11, 32'h111,  0, 0,  11, 0, 1, 0, 0, 0));
        tab.push_back(mk(1, 2, 22,           0, 0, 0,         0, 0,  11, 0, 1, 0, 0, 0));
        tab.push_back(mk(1, 3, 23,           0, 0, 0,         0, 0,  11, 0, 1, 0, 0, 0));
        tab.push_back(mk(1, 4, 24,           0, 0, 0,         0, 0,  11, 0, 1, 0, 0, 0));
        tab.push_back(mk(1, 5, 25,           0, 0, 0,         0, 0,  11, 0, 1, 0, 0, 1));
        tab.push_back(mk(0, 0, 0,            0, 0, 0,         0, 0,  11, 0, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0,            0, 0, 0,         1, 0,  0, 0,  0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0,            0, 0, 0,         1, 9,  9, 0,  1, 0, 0, 0));
        tab.push_back(mk(0, 0, 0,            0, 0, 0,         1, 9,  9, 0,  1, 0, 1, 0));
        tab.push_back(mk(0, 0, 0,            1, 0, 32'h55,    0, 0,  9, 0,  1, 0, 1, 0));
        tab.push_back(mk(0, 0, 0,            0, 0, 0,         0, 0,  9, 0,  1, 0, 1, 0));
        tab.push_back(mk(1, 0, 32'h99,       0, 0, 0,         0, 0,  9, 0,  1, 0, 1, 0));
        run_tab("main");

        // reset in the middle of traffic: FIFO full, r7 busy, err set
        tab.push_back(mk(0, 0, 0,            0, 0, 0,         1, 7,  7, 6,  1, 0, 1, 0));
        tab.push_back(mk(1, 1, 32'h31,       1, 7, 7,         1, 6,  7, 6,  1, 1, 1, 0));
        tab.push_back(mk(1, 2, 32'h32,       1, 6, 6,         0, 0,  7, 6,  1, 1, 1, 0));
        run_tab("pre_rst");
        check("pre_rst full", 32'(lu_ready), 0);
        check("pre_rst w_en", 32'(w_en), 1);
        clr_n = 1'b0;
        #1;
        check("async_rst w_en", 32'(w_en), 0);
        check("async_rst lu_ready", 32'(lu_ready), 1);
        check("async_rst busy_a", 32'(busy_a), 0);
        check("async_rst err", 32'(err), 0);
        check("async_rst w_number", 32'(w_number), 0);
        idle_inputs();
        model_reset();
        #2;
        clr_n = 1'b1;

        // pipe keeps writing while pipe_hold is up: error, pipe still wins
        tab.push_back(mk(0, 0, 0,            0, 0, 0,         1, 12, 12, 0, 1, 0, 0, 0));
        tab.push_back(mk(1, 1, 32'h41,       1, 12, 32'hC,    0, 0,  12, 0, 1, 0, 0, 0));
        tab.push_back(mk(1, 2, 32'h42,       0, 0, 0,         0, 0,  12, 0, 1, 0, 0, 0));
        tab.push_back(mk(1, 3, 32'h43,       0, 0, 0,         0, 0,  12, 0, 1, 0, 0, 0));
        tab.push_back(mk(1, 4, 32'h44,       0, 0, 0,         0, 0,  12, 0, 1, 0, 0, 0));
        tab.push_back(mk(1, 5, 32'h45,       0, 0, 0,         0, 0,  12, 0, 1, 0, 0, 1));
        tab.push_back(mk(1, 6, 32'h46,       0, 0, 0,         0, 0,  12, 0, 1, 0, 1, 1));
        tab.push_back(mk(0, 0, 0,            0, 0, 0,         0, 0,  12, 0, 0, 0, 1, 0));
        run_tab("hold");

        clr_n = 1'b0;
        model_reset();
        #2;
        clr_n = 1'b1;

        // long-unit result for a register that was never issued
        tab.push_back(mk(0, 0, 0,            1, 13, 5,        0, 0,  13, 0, 0, 0, 1, 0));
        tab.push_back(mk(0, 0, 0,            0, 0, 0,         0, 0,  13, 0, 0, 0, 1, 0));
        run_tab("unissued");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
